// File: rtl/idct_pkg.sv
// Shared sizing and types for the IDCT streaming controller.
package idct_pkg;
  localparam int unsigned IDCT_N       = 64;
  localparam int unsigned IDCT_W       = 16;
  localparam int unsigned IDCT_LATENCY = 29;

  typedef logic signed [IDCT_W-1:0] coef_t;

  typedef enum logic {
    OBUF_EMPTY = 1'b0,
    OBUF_FULL  = 1'b1
  } ostate_t;
endpackage

// File: rtl/idct_valid_pipe.sv
// Valid shift register matching the IDCT pipeline depth; any = a block is in flight.
module idct_valid_pipe #(
  parameter int unsigned LATENCY = 29
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic any
);
  logic [LATENCY-1:0] stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage <= '0;
    else     stage <= (stage << 1) | LATENCY'(in);
  end

  assign out = stage[LATENCY-1];
  assign any = |stage;
endmodule

// File: rtl/idct_stream_ctrl.sv
// Deserializes a coefficient stream into a block, launches it into the IDCT only
// when its result is guaranteed a landing slot, and serializes the result out.
module idct_stream_ctrl
  import idct_pkg::*;
#(
  parameter int unsigned LATENCY = IDCT_LATENCY,
  parameter int unsigned N       = IDCT_N,
  parameter int unsigned W       = IDCT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic [N*W-1:0] idct_x,
  input  logic [N*W-1:0] idct_out,
  output logic           busy,
  output logic           frame_err
);
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [N*W-1:0] ibuf, obuf;
  logic [CW-1:0]  icnt, ocnt;
  logic           ifull, ofull;
  logic           launch, inflight, capture;
  logic           in_fire, out_fire;
  ostate_t        ostate, ostate_nxt;

  assign in_ready = !ifull;
  assign in_fire  = in_valid && !ifull;
  assign out_fire = ofull && out_ready;
  // Single block between launch and drain, so capture can never hit a full obuf.
  assign launch   = ifull && !inflight && !ofull;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ibuf      <= '0;
      icnt      <= '0;
      ifull     <= 1'b0;
      frame_err <= 1'b0;
      idct_x    <= '0;
    end else begin
      if (in_fire) begin
        ibuf[icnt*W +: W] <= in_data;
        if (in_last != (icnt == LAST)) frame_err <= 1'b1;
        icnt <= (icnt == LAST) ? '0 : icnt + 1'b1;
        if (icnt == LAST) ifull <= 1'b1;
      end
      if (launch) begin
        idct_x <= ibuf;
        ifull  <= 1'b0;
      end
    end
  end

  idct_valid_pipe #(.LATENCY(LATENCY)) u_vpipe (
    .clk (clk),
    .rst (rst),
    .in  (launch),
    .out (capture),
    .any (inflight)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ostate <= OBUF_EMPTY;
    else     ostate <= ostate_nxt;
  end

  always_comb begin
    ostate_nxt = ostate;
    case (ostate)
      OBUF_EMPTY: if (capture) ostate_nxt = OBUF_FULL;
      OBUF_FULL:  if (out_fire && ocnt == LAST) ostate_nxt = OBUF_EMPTY;
    endcase
  end

  always_comb begin
    ofull = (ostate == OBUF_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obuf <= '0;
      ocnt <= '0;
    end else if (capture) begin
      obuf <= idct_out;
      ocnt <= '0;
    end else if (out_fire) begin
      ocnt <= (ocnt == LAST) ? '0 : ocnt + 1'b1;
    end
  end

  assign out_valid = ofull;
  assign out_data  = obuf[ocnt*W +: W];
  assign out_last  = ofull && (ocnt == LAST);
  assign busy      = ifull || inflight || ofull;
endmodule

// File: doc/idct_stream_ctrl.md
# idct_stream_ctrl

Streaming front/back-end controller for the 64-input, fixed-latency `IDCT` pipeline. It deserializes a 64-beat coefficient stream into one 8x8 block and launches the block into the pipeline. It tracks the in-flight block with a valid pipe that matches the IDCT latency, captures the result, and serializes it out under valid/ready. The IDCT itself has no stall or valid signals, so this block owns all flow control: no block is launched unless its result is guaranteed a landing slot.

## Interface
Parameters:
- `LATENCY`, 29: IDCT pipeline depth in cycles, from `idct_x` change to the matching `idct_out`.
- `N`, 64: coefficients per block.
- `W`, 16: coefficient width, signed.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: input beat valid.
- `in_ready`, out, 1: input beat accepted when high together with `in_valid`.
- `in_data`, in, W: coefficient, row-major order, index 0 first.
- `in_last`, in, 1: marks beat N-1; used for checking only.
- `out_valid`, out, 1: output beat valid.
- `out_ready`, in, 1: downstream accepts the beat.
- `out_data`, out, W: result sample, row-major order, index 0 first.
- `out_last`, out, 1: high on beat N-1.
- `idct_x`, out, N*W: block to IDCT; element k at [W*k+W-1 : W*k].
- `idct_out`, in, N*W: IDCT result, same packing.
- `busy`, out, 1: input buffer full, block in flight, or output buffer occupied.
- `frame_err`, out, 1: sticky flag; `in_last` was seen at the wrong beat.

## Operation
- Input buffer `ibuf` (N×W), beat counter `icnt` (0..N-1), flag `ifull`.
  - `in_ready = !ifull`.
  - An accepted beat writes `ibuf[icnt]` and increments `icnt`.
  - At `icnt == N-1` the beat is written, `icnt` wraps to 0, and `ifull` is set.
- Framing check:
  - `in_last` high on an accepted beat with `icnt != N-1`, or low with `icnt == N-1`, sets `frame_err`.
  - Framing is driven by `icnt` only; `in_last` never truncates or extends a block.
- Launch condition (combinational):
  - `launch = ifull && !inflight && !ofull`.
  - `inflight` is the OR of all bits of the valid pipe.
  - At most one block is ever between launch and drain completion.
- On launch:
  - `idct_x <= ibuf`.
  - `ifull <= 0`.
  - Valid pipe bit 0 is set.
  - `idct_x` holds that value until the next launch.
- Valid pipe:
  - LATENCY-stage shift register, shifts every cycle.
  - When the last stage is high, `obuf <= idct_out`, `ofull <= 1`, and `ocnt <= 0`.
- Output:
  - `out_valid = ofull`; `out_data = obuf[ocnt]`; `out_last = ofull && ocnt == N-1`.
  - On `out_valid && out_ready`, `ocnt` increments.
  - At beat N-1, `ofull` clears and `ocnt` wraps to 0.
- Output states:
  - EMPTY (`!ofull`) goes to FULL on capture.
  - FULL goes to EMPTY on the last-beat handshake.
  - Capture while FULL cannot occur because of the launch condition.

## Timing
- Reset values:
  - `in_ready` = 1.
  - `out_valid`, `out_last`, `busy`, `frame_err` = 0.
  - `out_data` = 0; `idct_x` = 0.
  - Counters and valid pipe are cleared.
- Reset mid-operation:
  - Partial input block, in-flight block and output block are all discarded.
  - Stale `idct_out` is ignored because the valid pipe is cleared.
- Last input beat accepted in cycle A:
  - `ifull` and `in_ready = 0` in cycle A+1.
  - `launch` in A+1, if legal.
  - New `idct_x` and `in_ready = 1` in cycle A+2.
  - Capture at the end of cycle A+1+LATENCY; `out_valid` first high in cycle A+2+LATENCY.
- Overlap: the next block may be filling `ibuf` while a block is in flight or draining. Its launch waits for `!inflight && !ofull`.
- Same-cycle last output handshake and `ifull`:
  - `launch` is not taken that cycle; `ofull` is still 1.
  - It is taken the next cycle.
- Streaming cost: fill takes N cycles, then the IDCT LATENCY, then the drain takes N cycles, with fill overlapped.
- `out_ready` low: `out_data` and `out_last` hold stable.

## Structure
- Package `idct_pkg`: `IDCT_N` = 64, `IDCT_W` = 16, `IDCT_LATENCY` = 29, and `typedef logic signed [IDCT_W-1:0] coef_t`.
- Sub-module `idct_valid_pipe` (params `LATENCY`; ports `clk`, `rst`, `in`, `out`, `any`): the latency-matching valid shift register.
- The IDCT is not instantiated inside; the integration top connects `idct_x`/`idct_out` to `IDCT`.

## Test plan
- DC block through a real `IDCT`:
  - Stimulus: input 23, -1, -2, then 61 zeros, `out_ready` = 1.
  - Required: 64 outputs; columns 0 are 2, all others 3; `out_last` only on beat 63; first `out_valid` exactly LATENCY+2 cycles after the last input handshake.
- Back-to-back blocks:
  - Stimulus: second block streamed immediately.
  - Required: `in_ready` low only while `ifull`; second launch occurs the cycle after the first drain completes; results in order.
- Output backpressure:
  - Stimulus: `out_ready` toggling 1,0,0,1 pattern.
  - Required: `out_data` stable while stalled; no beat lost or duplicated; `launch` held off while `ofull`.
- Framing:
  - Stimulus: `in_last` at beat 10.
  - Required: `frame_err` = 1 and stays set; the block still completes at 64 beats.
- Reset at beat 30 of input, and again while a block is in flight:
  - Required: all outputs return to their reset values; no `out_valid` from the discarded block; a fresh block then produces correct results.
